// File: rtl/mul_pkg.sv
// Shared helpers and stage record for the pipelined multiplier.
// Signed operation is enabled by defining MUL_PIPE_SIGNED_EN.
package mul_pkg;

   localparam int DEF_A_W   = 64;
   localparam int DEF_B_W   = 64;
   localparam int DEF_TAG_W = 8;

   function automatic int nchunks(input int b_w, input int chunk_w);
      return b_w / chunk_w;
   endfunction

   // Stage 0 only registers operands unless it is the sole stage.
   function automatic int chunk_stage(input int k, input int nch,
                                      input int stages);
      if (stages <= 1) return 0;
      return 1 + (k * (stages - 1)) / nch;
   endfunction

   typedef struct packed {
      logic                           valid;
      logic [DEF_TAG_W-1:0]           tag;
      logic [DEF_A_W+DEF_B_W-1:0]     acc;
      logic [DEF_A_W-1:0]             a;
      logic [DEF_B_W-1:0]             b_rem;
   } mul_stage_t;

endpackage

// File: rtl/mul_pp_chunk.sv
// One A x CHUNK partial product, shifted to its weight.
// MUL_PIPE_SIGNED_EN: A is signed; the top chunk of B is signed too.
module mul_pp_chunk #(
   parameter int A_W     = 64,
   parameter int CHUNK_W = 16,
   parameter int P_W     = 128,
   parameter int SHIFT   = 0,
   parameter bit TOP     = 1'b0
) (
   input  logic [A_W-1:0]     i_a,
   input  logic [CHUNK_W-1:0] i_b,
   output logic [P_W-1:0]     o_pp
);

   localparam int M_W = A_W + CHUNK_W;

   logic [M_W-1:0] w_ax;
   logic [M_W-1:0] w_bx;
   logic [M_W-1:0] w_m;
   logic [P_W-1:0] w_ext;

`ifdef MUL_PIPE_SIGNED_EN
   assign w_ax  = {{CHUNK_W{i_a[A_W-1]}}, i_a};
   assign w_bx  = TOP ? {{A_W{i_b[CHUNK_W-1]}}, i_b}
                      : {{A_W{1'b0}}, i_b};
   // Product fits in M_W bits as a signed value, so truncation is exact.
   assign w_m   = w_ax * w_bx;
   assign w_ext = P_W'($signed(w_m));
`else
   assign w_ax  = {{CHUNK_W{1'b0}}, i_a};
   assign w_bx  = {{A_W{1'b0}}, i_b};
   assign w_m   = w_ax * w_bx;
   assign w_ext = P_W'(w_m);
`endif

   assign o_pp = w_ext << SHIFT;

endmodule

// File: rtl/mul_pipe.sv
// Pipelined A x B multiplier with valid/ready handshake and tag sideband.
// Define MUL_PIPE_SIGNED_EN for two's complement operands.
module mul_pipe
   import mul_pkg::*;
#(
   parameter int A_W     = 64,
   parameter int B_W     = 64,
   parameter int CHUNK_W = 16,
   parameter int STAGES  = 4,
   parameter int TAG_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_W-1:0]     in_a,
   input  logic [B_W-1:0]     in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [A_W+B_W-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int P_W = A_W + B_W;
   localparam int NCH = nchunks(B_W, CHUNK_W);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [P_W-1:0]   acc;
      logic [A_W-1:0]   a;
      logic [B_W-1:0]   b_rem;
   } stage_t;

   stage_t         r_st  [STAGES];
   logic [P_W-1:0] w_pp  [NCH];
   logic [P_W-1:0] w_sum [STAGES];
   logic           w_stall;
   logic           w_take;

   assign w_stall  = r_st[STAGES-1].valid & ~out_ready;
   assign in_ready = ~w_stall & ~flush;
   assign w_take   = in_valid & in_ready;

   for (genvar k = 0; k < NCH; k++) begin : g_pp
      localparam int ST = chunk_stage(k, NCH, STAGES);
      logic [A_W-1:0]     w_a;
      logic [CHUNK_W-1:0] w_b;
      if (ST == 0) begin : g_in
         assign w_a = in_a;
         assign w_b = in_b[k*CHUNK_W +: CHUNK_W];
      end else begin : g_reg
         assign w_a = r_st[ST-1].a;
         assign w_b = r_st[ST-1].b_rem[k*CHUNK_W +: CHUNK_W];
      end
      mul_pp_chunk #(
         .A_W     (A_W),
         .CHUNK_W (CHUNK_W),
         .P_W     (P_W),
         .SHIFT   (k * CHUNK_W),
         .TOP     (k == NCH - 1)
      ) u_pp (
         .i_a  (w_a),
         .i_b  (w_b),
         .o_pp (w_pp[k])
      );
   end

   always_comb begin
      for (int s = 0; s < STAGES; s++) begin
         w_sum[s] = '0;
         for (int k = 0; k < NCH; k++) begin
            if (chunk_stage(k, NCH, STAGES) == s)
               w_sum[s] = w_sum[s] + w_pp[k];
         end
      end
   end

   // Data only loads behind a valid op, so outputs hold across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++)
            r_st[s] <= '0;
      end else if (flush) begin
         for (int s = 0; s < STAGES; s++)
            r_st[s].valid <= 1'b0;
      end else if (!w_stall) begin
         r_st[0].valid <= w_take;
         if (w_take) begin
            r_st[0].tag   <= in_tag;
            r_st[0].acc   <= w_sum[0];
            r_st[0].a     <= in_a;
            r_st[0].b_rem <= in_b;
         end
         for (int s = 1; s < STAGES; s++) begin
            r_st[s].valid <= r_st[s-1].valid;
            if (r_st[s-1].valid) begin
               r_st[s].tag   <= r_st[s-1].tag;
               r_st[s].acc   <= r_st[s-1].acc + w_sum[s];
               r_st[s].a     <= r_st[s-1].a;
               r_st[s].b_rem <= r_st[s-1].b_rem;
            end
         end
      end
   end

   assign out_valid = r_st[STAGES-1].valid;
   assign out_p     = r_st[STAGES-1].acc;
   assign out_tag   = r_st[STAGES-1].tag;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed-vector bench for mul_pipe with a queue scoreboard for streams.
// Expected values follow MUL_PIPE_SIGNED_EN when it is defined.
module tb_mul_pipe;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_a;
   logic [63:0]  in_b;
   logic [7:0]   in_tag;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_p;
   logic [7:0]   out_tag;

   always #5 clk = ~clk;

   mul_pipe #(
      .A_W     (64),
      .B_W     (64),
      .CHUNK_W (16),
      .STAGES  (4),
      .TAG_W   (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag)
   );

   typedef struct {
      logic [63:0]  a;
      logic [63:0]  b;
      logic [7:0]   tag;
      logic [127:0] eu;
      logic [127:0] es;
   } vec_t;

   typedef struct {
      logic [127:0] p;
      logic [7:0]   tag;
   } exp_t;

   vec_t   tbl [11];
   exp_t   q [$];
   exp_t   m_e;
   int     n_vec = 0;
   int     n_bad = 0;
   int     n_rcv = 0;
   bit     sb_en = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] model(input logic [63:0] a,
                                          input logic [63:0] b);
`ifdef MUL_PIPE_SIGNED_EN
      logic signed [127:0] sa;
      logic signed [127:0] sb;
      sa = $signed({{64{a[63]}}, a});
      sb = $signed({{64{b[63]}}, b});
      return sa * sb;
`else
      return {64'b0, a} * {64'b0, b};
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_op();
      in_a   = {$urandom, $urandom};
      in_b   = {$urandom, $urandom};
      in_tag = 8'($urandom);
   endtask

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
      end else if (sb_en) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL spurious output: out_p %h tag %h",
                        out_p, out_tag);
            end else begin
               m_e = q.pop_front();
               chk("sb out_p", out_p, m_e.p);
               chk("sb out_tag", 128'(out_tag), 128'(m_e.tag));
               n_rcv++;
            end
         end
         if (flush) q.delete();
         if (in_valid && in_ready)
            q.push_back('{model(in_a, in_b), in_tag});
      end
   end

   initial begin
      int lat;
      int base;
      int cnt;
      int sent;
      int cyc;
      bit took;
      logic [127:0] exp_p;

      tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h5A,
                  128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
                  128'h1};
      tbl[1]  = '{64'h0, 64'hDEAD_BEEF_CAFE_F00D, 8'h01,
                  128'h0, 128'h0};
      tbl[2]  = '{64'h1, 64'h0123_4567_89AB_CDEF, 8'h02,
                  128'h0123_4567_89AB_CDEF, 128'h0123_4567_89AB_CDEF};
      tbl[3]  = '{64'h8000_0000_0000_0000, 64'h2, 8'h03,
                  128'h0000_0000_0000_0001_0000_0000_0000_0000,
                  128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000};
      tbl[4]  = '{64'h1_0000, 64'hFFFF, 8'h04,
                  128'hFFFF_0000, 128'hFFFF_0000};
      tbl[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 8'h05,
                  128'hFFFF_FFFF_FFFF_FFFF,
                  128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
      tbl[6]  = '{64'h1_0000_0000, 64'h1_0000_0000, 8'h06,
                  128'h0000_0000_0000_0001_0000_0000_0000_0000,
                  128'h0000_0000_0000_0001_0000_0000_0000_0000};
      tbl[7]  = '{64'h3, 64'h5, 8'h07, 128'hF, 128'hF};
      tbl[8]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h5, 8'h08,
                  128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1,
                  128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1};
      tbl[9]  = '{64'hFFFF, 64'hFFFF_0000, 8'h09,
                  128'hFFFE_0001_0000, 128'hFFFE_0001_0000};
      tbl[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0001, 8'h0A,
                  128'h0000_0000_0000_0001_0000_FFFF_FFFF_FFFE_FFFF,
                  128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE_FFFF};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_tag = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("reset out_valid", 128'(out_valid), 128'd0);
      chk("reset out_p", out_p, 128'd0);
      chk("reset out_tag", 128'(out_tag), 128'd0);
      chk("reset in_ready", 128'(in_ready), 128'd1);

      exp_p = '0;
      for (int i = 0; i < 11; i++) begin
         in_a = tbl[i].a; in_b = tbl[i].b; in_tag = tbl[i].tag;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 20) begin
            tick();
            lat++;
         end
`ifdef MUL_PIPE_SIGNED_EN
         exp_p = tbl[i].es;
`else
         exp_p = tbl[i].eu;
`endif
         chk($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
         chk($sformatf("vec%0d out_p", i), out_p, exp_p);
         chk($sformatf("vec%0d out_tag", i), 128'(out_tag),
             128'(tbl[i].tag));
         tick();
      end
      chk("idle out_valid", 128'(out_valid), 128'd0);
      chk("idle out_p hold", out_p, exp_p);

      // Stall: output must freeze and in_ready must drop.
      out_ready = 1'b0;
      in_a = 64'h3; in_b = 64'h5; in_tag = 8'h33; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("stall latency", 128'(lat), 128'd4);
      chk("stall in_ready", 128'(in_ready), 128'd0);
      repeat (3) tick();
      chk("stall out_valid", 128'(out_valid), 128'd1);
      chk("stall out_p", out_p, 128'd15);
      chk("stall out_tag", 128'(out_tag), 128'h33);
      out_ready = 1'b1;
      tick();
      chk("stall release", 128'(out_valid), 128'd0);

      // Back-to-back stream, one result per cycle.
      sb_en = 1'b1;
      base = n_rcv;
      for (int i = 0; i < 100; i++) begin
         rnd_op();
         if (i == 7) begin in_a = '1; in_b = '1; end
         in_valid = 1'b1;
         tick();
      end
      chk("stream mid count", 128'(n_rcv - base), 128'd96);
      in_valid = 1'b0;
      repeat (4) tick();
      chk("stream count", 128'(n_rcv - base), 128'd100);

      // Random backpressure.
      base = n_rcv; sent = 0; cyc = 0;
      rnd_op();
      while (sent < 50 && cyc < 2000) begin
         in_valid = 1'b1;
         out_ready = 1'($urandom_range(0, 1));
         #1;
         chk("bp in_ready", 128'(in_ready),
             128'(!(out_valid && !out_ready)));
         took = in_ready;
         @(posedge clk); #1;
         cyc++;
         if (took) begin
            sent++;
            rnd_op();
         end
      end
      chk("bp sent", 128'(sent), 128'd50);
      in_valid = 1'b0; out_ready = 1'b1;
      cnt = 0;
      while (q.size() > 0 && cnt < 50) begin
         tick();
         cnt++;
      end
      chk("bp count", 128'(n_rcv - base), 128'd50);

      // Flush with three ops in flight.
      base = n_rcv;
      for (int i = 0; i < 3; i++) begin
         rnd_op();
         in_valid = 1'b1;
         tick();
      end
      flush = 1'b1; in_tag = 8'hEE;
      #1;
      chk("flush in_ready", 128'(in_ready), 128'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) cnt++;
         tick();
      end
      chk("flush dropped", 128'(cnt), 128'd0);
      in_a = 64'h7; in_b = 64'h9; in_tag = 8'h42; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("post-flush latency", 128'(lat), 128'd4);
      chk("post-flush tag", 128'(out_tag), 128'h42);
      tick();
      chk("post-flush count", 128'(n_rcv - base), 128'd1);

      // Reset with the pipe full.
      for (int i = 0; i < 6; i++) begin
         rnd_op();
         in_valid = 1'b1;
         out_ready = (i < 4) ? 1'b1 : 1'b0;
         tick();
      end
      chk("full before reset", 128'(out_valid), 128'd1);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid-reset out_valid", 128'(out_valid), 128'd0);
      chk("mid-reset out_p", out_p, 128'd0);
      chk("mid-reset out_tag", 128'(out_tag), 128'd0);
      chk("mid-reset in_ready", 128'(in_ready), 128'd1);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) cnt++;
         tick();
      end
      chk("mid-reset leak", 128'(cnt), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
